press_count_display: RTL and testbench

//  Downstream consumer of the debounced one-cycle button pulses. Keeps a two-digit BCD

---
 rtl/press_count_display.sv | 134 +++++++++++++
 tb/tb_press_count_display.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/press_count_display.sv
// Two-digit BCD up/down press counter with active-low 7-segment outputs.
// Optional wrap or saturation; the display blanks for a fixed window after a wrap.
module press_count_display #(
  parameter int MAX_COUNT    = 99,
  parameter int WRAP         = 1,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int BLANK_LZ     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_pulse,
  input  logic       dec_pulse,
  input  logic       clr,
  output logic [7:0] count,
  output logic       wrap_evt,
  output logic [0:6] HEX1,
  output logic [0:6] HEX0
);

  localparam int TW =
    (BLINK_CYCLES > 0) ? $clog2(BLINK_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(BLINK_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_COUNT % 10);
  localparam logic [7:0] MAX_BCD = {MAX_T, MAX_U};
  localparam logic BLINK_EN = (BLINK_CYCLES > 0);
  localparam logic WRAP_EN  = (WRAP != 0);
  localparam logic LZ_EN    = (BLANK_LZ != 0);
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  typedef enum logic {
    SHOW,
    DARK
  } blink_t;

  blink_t        state;
  logic [TW-1:0] timer;

  logic [3:0] tens;
  logic [3:0] units;
  logic [7:0] cnt_inc;
  logic [7:0] cnt_dec;
  logic       step_up;
  logic       step_dn;
  logic       at_max;
  logic       at_min;
  logic       wrap_hit;

  assign tens    = count[7:4];
  assign units   = count[3:0];
  assign step_up = inc_pulse & ~dec_pulse;
  assign step_dn = dec_pulse & ~inc_pulse;
  assign at_max  = (count == MAX_BCD);
  assign at_min  = (count == 8'h00);
  assign wrap_hit = WRAP_EN &
    ((step_up & at_max) | (step_dn & at_min));

  always_comb begin
    cnt_inc = {tens, units + 4'd1};
    cnt_dec = {tens, units - 4'd1};
    if (units == 4'd9)
      cnt_inc = {tens + 4'd1, 4'd0};
    if (units == 4'd0)
      cnt_dec = {tens - 4'd1, 4'd9};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count    <= 8'h00;
      wrap_evt <= 1'b0;
      state    <= SHOW;
      timer    <= '0;
    end else begin
      wrap_evt <= wrap_hit;
      if (step_up) begin
        if (!at_max)
          count <= cnt_inc;
        else if (WRAP_EN)
          count <= 8'h00;
      end
      if (step_dn) begin
        if (!at_min)
          count <= cnt_dec;
        else if (WRAP_EN)
          count <= MAX_BCD;
      end
      // A wrap during DARK restarts the window
      if (wrap_hit && BLINK_EN) begin
        state <= DARK;
        timer <= T_LOAD;
      end else if (state == DARK) begin
        if (timer == T_ONE) begin
          state <= SHOW;
          timer <= '0;
        end else begin
          timer <= timer - T_ONE;
        end
      end
    end
  end

  function automatic logic [0:6] seg7(
    input logic [3:0] d
  );
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  always_comb begin
    HEX0 = seg7(units);
    HEX1 = seg7(tens);
    if (LZ_EN && tens == 4'd0)
      HEX1 = SEG_OFF;
    if (state == DARK) begin
      HEX0 = SEG_OFF;
      HEX1 = SEG_OFF;
    end
  end

endmodule

// File: tb/tb_press_count_display.sv
// Bench for press_count_display: three parameter sets driven in parallel,
// directed vectors plus random traffic against an integer reference model.
module tb_press_count_display;

  localparam int ND = 3;
  localparam int P_MAX   [ND] = '{99, 99, 50};
  localparam int P_WRAP  [ND] = '{1, 0, 1};
  localparam int P_BLINK [ND] = '{4, 0, 10};
  localparam int P_LZ    [ND] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inc_pulse = 1'b0;
  logic dec_pulse = 1'b0;
  logic clr = 1'b0;
  logic [7:0] cnt [ND];
  logic       we  [ND];
  logic [0:6] h1  [ND];
  logic [0:6] h0  [ND];

  always #5 clk = ~clk;

  press_count_display #(
    .MAX_COUNT(99), .WRAP(1), .BLINK_CYCLES(4), .BLANK_LZ(1)
  ) u_a (
    .clk(clk), .rst(rst), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .count(cnt[0]),
    .wrap_evt(we[0]), .HEX1(h1[0]), .HEX0(h0[0])
  );

  press_count_display #(
    .MAX_COUNT(99), .WRAP(0), .BLINK_CYCLES(0), .BLANK_LZ(0)
  ) u_b (
    .clk(clk), .rst(rst), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .count(cnt[1]),
    .wrap_evt(we[1]), .HEX1(h1[1]), .HEX0(h0[1])
  );

  press_count_display #(
    .MAX_COUNT(50), .WRAP(1), .BLINK_CYCLES(10), .BLANK_LZ(1)
  ) u_c (
    .clk(clk), .rst(rst), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .count(cnt[2]),
    .wrap_evt(we[2]), .HEX1(h1[2]), .HEX0(h0[2])
  );

  logic [6:0] SEG [10];
  localparam logic [6:0] OFF = 7'b1111111;

  int  m_v  [ND];
  int  m_dk [ND];
  bit  m_we [ND];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_h0(input int d);
    if (m_dk[d] > 0) return OFF;
    return SEG[m_v[d] % 10];
  endfunction

  function automatic logic [6:0] exp_h1(input int d);
    if (m_dk[d] > 0) return OFF;
    if (P_LZ[d] != 0 && m_v[d] / 10 == 0) return OFF;
    return SEG[m_v[d] / 10];
  endfunction

  task automatic model_step(input bit r, input bit c,
                            input bit i, input bit dn);
    for (int d = 0; d < ND; d++) begin
      bit wrapped;
      wrapped = 1'b0;
      if (r || c) begin
        m_v[d] = 0;
        m_dk[d] = 0;
      end else begin
        if (i && !dn) begin
          if (m_v[d] < P_MAX[d]) m_v[d]++;
          else if (P_WRAP[d] != 0) begin
            m_v[d] = 0;
            wrapped = 1'b1;
          end
        end else if (dn && !i) begin
          if (m_v[d] > 0) m_v[d]--;
          else if (P_WRAP[d] != 0) begin
            m_v[d] = P_MAX[d];
            wrapped = 1'b1;
          end
        end
        if (wrapped && P_BLINK[d] > 0) m_dk[d] = P_BLINK[d];
        else if (m_dk[d] > 0) m_dk[d]--;
      end
      m_we[d] = wrapped;
    end
  endtask

  task automatic step(input bit r, input bit c,
                      input bit i, input bit dn);
    rst = r;
    clr = c;
    inc_pulse = i;
    dec_pulse = dn;
    @(posedge clk);
    model_step(r, c, i, dn);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("dut%0d count", d), 32'(cnt[d]),
          32'(to_bcd(m_v[d])));
      chk($sformatf("dut%0d wrap_evt", d), 32'(we[d]),
          32'(m_we[d]));
      chk($sformatf("dut%0d HEX0", d), 32'(h0[d]),
          32'(exp_h0(d)));
      chk($sformatf("dut%0d HEX1", d), 32'(h1[d]),
          32'(exp_h1(d)));
    end
  endtask

  typedef struct {
    bit r;
    bit c;
    bit i;
    bit dn;
    logic [7:0] cnt;
    bit we;
    bit dark;
  } vec_t;

  vec_t tv [8];

  initial begin
    SEG = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100};
    for (int d = 0; d < ND; d++) begin
      m_v[d] = 0;
      m_dk[d] = 0;
      m_we[d] = 1'b0;
    end
    // Vectors for DUT A, starting from count 12
    tv[0] = '{0, 0, 1, 1, 8'h12, 0, 0};
    tv[1] = '{0, 1, 1, 0, 8'h00, 0, 0};
    tv[2] = '{0, 0, 0, 1, 8'h99, 1, 1};
    tv[3] = '{0, 0, 0, 0, 8'h99, 0, 1};
    tv[4] = '{0, 0, 1, 0, 8'h00, 1, 1};
    tv[5] = '{0, 0, 1, 0, 8'h01, 0, 1};
    tv[6] = '{0, 0, 0, 1, 8'h00, 0, 1};
    tv[7] = '{1, 0, 1, 0, 8'h00, 0, 0};

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset count", 32'(cnt[0]), 32'h00);
    chk("reset HEX0", 32'(h0[0]), 32'(SEG[0]));
    chk("reset HEX1 blank", 32'(h1[0]), 32'(OFF));
    chk("reset HEX1 zero", 32'(h1[1]), 32'(SEG[0]));
    chk("reset wrap_evt", 32'(we[0]), 32'd0);

    for (int k = 0; k < 12; k++) begin
      step(0, 0, 1, 0);
      if (k == 11) begin
        chk("twelve count", 32'(cnt[0]), 32'h12);
        chk("twelve HEX1", 32'(h1[0]), 32'(SEG[1]));
        chk("twelve HEX0", 32'(h0[0]), 32'(SEG[2]));
      end
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end

    for (int k = 0; k < 8; k++) begin
      bit dk;
      step(tv[k].r, tv[k].c, tv[k].i, tv[k].dn);
      dk = (h0[0] == OFF) && (h1[0] == OFF);
      chk($sformatf("vec%0d count", k), 32'(cnt[0]),
          32'(tv[k].cnt));
      chk($sformatf("vec%0d wrap", k), 32'(we[0]),
          32'(tv[k].we));
      chk($sformatf("vec%0d dark", k), 32'(dk),
          32'(tv[k].dark));
    end

    step(0, 0, 0, 1);
    chk("dec wrap count", 32'(cnt[0]), 32'h99);
    chk("dec wrap evt", 32'(we[0]), 32'd1);
    chk("dec sat count", 32'(cnt[1]), 32'h00);
    chk("dec sat evt", 32'(we[1]), 32'd0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("inc wrap count", 32'(cnt[0]), 32'h00);
    chk("inc wrap evt", 32'(we[0]), 32'd1);
    chk("inc wrap dark", 32'(h0[0]), 32'(OFF));
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 0, 0);
      chk($sformatf("dark%0d HEX0", k), 32'(h0[0]), 32'(OFF));
      chk($sformatf("dark%0d evt", k), 32'(we[0]), 32'd0);
    end
    step(0, 0, 0, 0);
    chk("post dark HEX0", 32'(h0[0]), 32'(SEG[0]));

    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1);
    chk("c mid count", 32'(cnt[2]), 32'h45);
    chk("c mid dark", 32'(h0[2]), 32'(OFF));
    step(1, 0, 0, 0);
    chk("c rst count", 32'(cnt[2]), 32'h00);
    chk("c rst HEX0", 32'(h0[2]), 32'(SEG[0]));
    chk("c rst evt", 32'(we[2]), 32'd0);

    for (int k = 0; k < 600; k++) begin
      int p;
      bit r, c, i, dn;
      p = $urandom_range(0, 99);
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 99) == 0);
      i = (p < 50) || (p >= 90);
      dn = (p >= 50);
      if ($urandom_range(0, 2) == 0) begin
        i = 1'b0;
        dn = 1'b0;
      end
      step(r, c, i, dn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
